// File: rtl/pipelined_circular_unshifter.sv
// rtl/pipelined_circular_unshifter.sv - pipelined left rotate within a per-beat lift size
// Capture stage plus SW rotate stages, all advancing together under a single global enable.
module pipelined_circular_unshifter #(
  parameter int MAXZ = 81,
  parameter int SW   = $clog2(MAXZ),
  parameter int ZW   = $clog2(MAXZ + 1)
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MAXZ-1:0] in_data,
  input  logic [SW-1:0]   shift_val,
  input  logic [ZW-1:0]   z_size,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MAXZ-1:0] out_data,
  output logic            out_last,
  output logic            out_err
);

  function automatic logic [MAXZ-1:0] z_mask(input logic [ZW-1:0] z);
    logic [MAXZ:0] one;
    logic [MAXZ:0] m;
    one = {{MAXZ{1'b0}}, 1'b1};
    m   = (one << z) - one;
    return m[MAXZ-1:0];
  endfunction

  // d is already clear above z, so bits pushed past z come back in via the right shift.
  function automatic logic [MAXZ-1:0] rotl_z(input logic [MAXZ-1:0] d,
                                             input logic [ZW-1:0]   z,
                                             input logic [SW-1:0]   amt);
    logic [ZW:0] back;
    back = (ZW+1)'(z) - (ZW+1)'(amt);
    return ((d << amt) | (d >> back)) & z_mask(z);
  endfunction

  logic            valid_q [0:SW];
  logic [MAXZ-1:0] data_q  [0:SW];
  logic [ZW-1:0]   z_q     [0:SW];
  logic [SW-1:0]   sh_q    [0:SW];
  logic            last_q  [0:SW];
  logic            err_q   [0:SW];

  logic            valid_d [0:SW];
  logic [MAXZ-1:0] data_d  [0:SW];
  logic [ZW-1:0]   z_d     [0:SW];
  logic [SW-1:0]   sh_d    [0:SW];
  logic            last_d  [0:SW];
  logic            err_d   [0:SW];

  logic adv;
  logic in_err;

  assign out_valid = valid_q[SW];
  assign out_data  = data_q[SW];
  assign out_last  = last_q[SW];
  assign out_err   = err_q[SW];
  assign adv       = !valid_q[SW] || out_ready;
  assign in_ready  = adv;

  always_comb begin
    in_err = (z_size == '0) || (z_size > ZW'(MAXZ)) || (ZW'(shift_val) >= z_size);

    valid_d[0] = in_valid;
    data_d[0]  = (in_valid && !in_err) ? (in_data & z_mask(z_size)) : '0;
    z_d[0]     = z_size;
    sh_d[0]    = shift_val;
    last_d[0]  = in_last;
    err_d[0]   = in_err;

    // Illegal beats carry zero data, so rotating them is harmless.
    for (int k = 0; k < SW; k++) begin
      valid_d[k+1] = valid_q[k];
      data_d[k+1]  = sh_q[k][k] ? rotl_z(data_q[k], z_q[k], SW'(1 << k)) : data_q[k];
      z_d[k+1]     = z_q[k];
      sh_d[k+1]    = sh_q[k];
      last_d[k+1]  = last_q[k];
      err_d[k+1]   = err_q[k];
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= SW; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        z_q[k]     <= '0;
        sh_q[k]    <= '0;
        last_q[k]  <= 1'b0;
        err_q[k]   <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k <= SW; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        z_q[k]     <= z_d[k];
        sh_q[k]    <= sh_d[k];
        last_q[k]  <= last_d[k];
        err_q[k]   <= err_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_circular_unshifter.sv
// tb/tb_pipelined_circular_unshifter.sv - directed bench for pipelined_circular_unshifter
module tb_pipelined_circular_unshifter;

  localparam int MAXZ = 81;
  localparam int SW   = 7;
  localparam int ZW   = 7;

  logic            CLK = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [MAXZ-1:0] in_data;
  logic [SW-1:0]   shift_val;
  logic [ZW-1:0]   z_size;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [MAXZ-1:0] out_data;
  logic            out_last;
  logic            out_err;

  pipelined_circular_unshifter #(.MAXZ(MAXZ)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_val(shift_val), .z_size(z_size), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [MAXZ-1:0] d;
    logic            l;
    logic            e;
  } exp_t;

  exp_t  expq[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  string phase        = "init";

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [MAXZ-1:0] model_rotl(input logic [MAXZ-1:0] d, input int s, input int z);
    logic [MAXZ-1:0] r;
    r = '0;
    for (int i = 0; i < z; i++) r[i] = d[(i - s + z) % z];
    return r;
  endfunction

  function automatic logic [MAXZ-1:0] rotr_full(input logic [MAXZ-1:0] d, input int s);
    logic [MAXZ-1:0] r;
    for (int i = 0; i < MAXZ; i++) r[i] = d[(i + s) % MAXZ];
    return r;
  endfunction

  // One clock: drive, check the head of the expected queue whenever out_valid, then step.
  task automatic cyc(input logic v, input logic [MAXZ-1:0] d, input int sh, input int z,
                     input logic l, input logic rdy, input logic [MAXZ-1:0] ed,
                     input logic ee, output logic acc);
    exp_t e;
    in_valid  = v;
    in_data   = d;
    shift_val = SW'(sh);
    z_size    = ZW'(z);
    in_last   = l;
    out_ready = rdy;
    #1;
    if (out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_out", out_valid, 1'b0);
      end else begin
        chk("data", out_data, expq[0].d);
        chk("last", out_last, expq[0].l);
        chk("err", out_err, expq[0].e);
        if (rdy) void'(expq.pop_front());
      end
    end
    acc = v && in_ready;
    if (acc) begin
      e.d = ed;
      e.l = l;
      e.e = ee;
      expq.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 60 && expq.size() > 0; n++) cyc(1'b0, '0, 0, 1, 1'b0, 1'b1, '0, 1'b0, acc);
    chk("drained", expq.size(), 0);
  endtask

  task automatic lat_test(input logic [MAXZ-1:0] d, input int s, input int z, input logic [MAXZ-1:0] ed);
    int lat;
    in_valid  = 1'b1;
    in_data   = d;
    shift_val = SW'(s);
    z_size    = ZW'(z);
    in_last   = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("lat_in_ready", in_ready, 1'b1);
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk("latency", lat, 8);
    chk("lat_data", out_data, ed);
    chk("lat_last", out_last, 1'b1);
    chk("lat_err", out_err, 1'b0);
    @(negedge CLK);
    chk("lat_consumed", out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic            acc;
    logic [MAXZ-1:0] all1;
    logic [MAXZ-1:0] pats [6];
    logic [95:0]     r96;
    logic [MAXZ-1:0] cur_d;
    int              cur_s;
    int              zs [3];
    int              i;

    all1    = '1;
    pats[0] = 81'd1;
    pats[1] = all1;
    pats[2] = 81'h0AAAA_AAAA_AAAA_AAAA_AAAA;
    pats[3] = 81'h1_0000_0000_0000_0000_0000;
    pats[4] = 81'h1DEAD_BEEF_CAFE_F00D_1234;
    pats[5] = 81'h0FFFF_0000_FFFF_0000_FFFF;
    zs[0] = 27; zs[1] = 54; zs[2] = 81;

    phase     = "reset";
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    shift_val = '0;
    z_size    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("out_valid", out_valid, 1'b0);
    chk("out_data", out_data, '0);
    chk("out_last", out_last, 1'b0);
    chk("out_err", out_err, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("in_ready", in_ready, 1'b1);

    phase = "single";
    lat_test(81'd1, 1, 81, 81'd2);

    phase = "wrap";
    cyc(1'b1, (81'd1 << 26) | (81'd1 << 60), 1, 27, 1'b1, 1'b1, 81'd1, 1'b0, acc);
    drain();

    phase = "boundary";
    cyc(1'b1, all1, 0, 1, 1'b0, 1'b1, 81'd1, 1'b0, acc);
    cyc(1'b1, all1, 0, 27, 1'b1, 1'b1, 81'h7FF_FFFF, 1'b0, acc);
    cyc(1'b1, 81'd1, 80, 81, 1'b0, 1'b1, 81'h1_0000_0000_0000_0000_0000, 1'b0, acc);
    cyc(1'b1, all1, 0, 81, 1'b1, 1'b1, all1, 1'b0, acc);
    drain();

    phase = "roundtrip";
    for (int p = 0; p < 6; p++) begin
      for (int s = 0; s < MAXZ; s++) begin
        cyc(1'b1, rotr_full(pats[p], s), s, 81, (s == 80), 1'b1, pats[p], 1'b0, acc);
        chk("accepted", acc, 1'b1);
      end
    end
    drain();

    phase = "backpressure";
    i = 0;
    r96 = {$urandom(), $urandom(), $urandom()};
    cur_d = r96[MAXZ-1:0];
    cur_s = $urandom_range(0, zs[0] - 1);
    for (int n = 0; n < 400 && i < 20; n++) begin
      cyc(1'b1, cur_d, cur_s, zs[i % 3], i[0], 1'($urandom_range(0, 1)),
          model_rotl(cur_d, cur_s, zs[i % 3]), 1'b0, acc);
      if (acc) begin
        i++;
        r96 = {$urandom(), $urandom(), $urandom()};
        cur_d = r96[MAXZ-1:0];
        cur_s = $urandom_range(0, zs[i % 3] - 1);
      end
    end
    chk("beats_sent", i, 20);
    drain();

    phase = "illegal";
    cyc(1'b1, 81'd1, 3, 27, 1'b0, 1'b1, 81'd8, 1'b0, acc);
    cyc(1'b1, all1, 30, 27, 1'b1, 1'b1, '0, 1'b1, acc);
    cyc(1'b1, all1, 0, 0, 1'b1, 1'b1, '0, 1'b1, acc);
    cyc(1'b1, all1, 5, 100, 1'b0, 1'b1, '0, 1'b1, acc);
    cyc(1'b1, all1, 27, 27, 1'b0, 1'b1, '0, 1'b1, acc);
    cyc(1'b1, 81'd3, 26, 27, 1'b1, 1'b1, (81'd1 << 26) | 81'd1, 1'b0, acc);
    cyc(1'b1, 81'd1, 80, 81, 1'b0, 1'b1, 81'd1 << 80, 1'b0, acc);
    drain();

    phase = "midreset";
    for (int b = 0; b < 5; b++) cyc(1'b1, 81'd1 << b, 1, 81, 1'b0, 1'b1, 81'd2 << b, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("idle_after_rst", out_valid, 1'b0);
      @(negedge CLK);
    end
    lat_test(81'h5, 2, 81, 81'h14);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
